jk_q_monitor: RTL



---
 rtl/jk_q_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/jk_q_monitor.sv
// jk_q_monitor: rise/fall pulses and per-window rise count / high time of a JK flop's Q.
// Define JK_Q_SYNC_EN to insert a two-flop synchroniser ahead of the Q sampler.
module jk_q_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             enable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow,
  output logic             window_done
);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);

  logic q_src;

`ifdef JK_Q_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = q_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_src = sync2_q;
`else
  assign q_src = q_in;
`endif

  state_t           state_q, state_d;
  logic [15:0]      win_q, win_d;
  logic             q_r_q, q_r_d, q_p_q, q_p_d;
  logic [CNT_W-1:0] rise_acc_q, rise_acc_d, high_acc_q, high_acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] rise_count_q, rise_count_d, high_time_q, high_time_d;
  logic             overflow_q, overflow_d, done_q, done_d;

  assign rise_pulse  = q_r_q & ~q_p_q;
  assign fall_pulse  = ~q_r_q & q_p_q;
  assign rise_count  = rise_count_q;
  assign high_time   = high_time_q;
  assign overflow    = overflow_q;
  assign window_done = done_q;

  always_comb begin
    q_r_d        = q_src;
    q_p_d        = q_r_q;
    state_d      = state_q;
    win_d        = win_q;
    rise_acc_d   = rise_acc_q;
    high_acc_d   = high_acc_q;
    sat_d        = sat_q;
    rise_count_d = rise_count_q;
    high_time_d  = high_time_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        rise_acc_d = '0;
        high_acc_d = '0;
        sat_d      = 1'b0;
        win_d      = '0;
        if (enable) state_d = MEASURE;
      end
      MEASURE: begin
        if (!enable) begin
          // Abort: discard the partial window, leave published results untouched.
          state_d    = IDLE;
          rise_acc_d = '0;
          high_acc_d = '0;
          sat_d      = 1'b0;
          win_d      = '0;
        end else begin
          if (rise_pulse) begin
            if (rise_acc_q == CNT_MAX) sat_d = 1'b1;
            else                       rise_acc_d = rise_acc_q + 1'b1;
          end
          if (q_r_q) begin
            if (high_acc_q == CNT_MAX) sat_d = 1'b1;
            else                       high_acc_d = high_acc_q + 1'b1;
          end
          if (win_q == WIN_LAST) begin
            state_d = DONE;
            win_d   = '0;
          end else begin
            win_d = win_q + 16'd1;
          end
        end
      end
      DONE: begin
        rise_count_d = rise_acc_q;
        high_time_d  = high_acc_q;
        overflow_d   = sat_q;
        done_d       = 1'b1;
        rise_acc_d   = '0;
        high_acc_d   = '0;
        sat_d        = 1'b0;
        win_d        = '0;
        state_d      = enable ? MEASURE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      win_q        <= '0;
      q_r_q        <= 1'b0;
      q_p_q        <= 1'b0;
      rise_acc_q   <= '0;
      high_acc_q   <= '0;
      sat_q        <= 1'b0;
      rise_count_q <= '0;
      high_time_q  <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      q_r_q        <= q_r_d;
      q_p_q        <= q_p_d;
      rise_acc_q   <= rise_acc_d;
      high_acc_q   <= high_acc_d;
      sat_q        <= sat_d;
      rise_count_q <= rise_count_d;
      high_time_q  <= high_time_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

endmodule
